// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Signed operations run on magnitudes; the sign is restored in a single FIX cycle.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc, step_acc, prod;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic               is_div, sign_diff, a_neg_r, div_zero;
    logic               op_arith, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, fix_hi, fix_lo;

    always_comb begin
        op_arith  = (op[2] == 1'b0);
        op_signed = ~op[0];
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        if (is_div) begin
            if (div_trial[WIDTH])
                step_acc = {acc[2*WIDTH-2:0], 1'b0};
            else
                step_acc = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = sign_diff ? -acc : acc;
        if (is_div) begin
            fix_lo = div_zero ? '1 : (sign_diff ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            fix_hi = a_neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            fix_lo = prod[WIDTH-1:0];
            fix_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && op_arith) state_next = CALC;
            CALC: begin
                if (flush)                            state_next = IDLE;
                else if (count == CNT_W'(WIDTH - 1))  state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            acc       <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            sign_diff <= 1'b0;
            a_neg_r   <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div    <= op[1];
                                sign_diff <= a_neg ^ b_neg;
                                a_neg_r   <= a_neg;
                                div_zero  <= (b == '0);
                                count     <= '0;
                                opnd      <= op[1] ? b_mag : a_mag;
                                acc       <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                            end
                            3'b100: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            3'b101: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc   <= step_acc;
                        count <= count + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: transaction-level reference model compared every cycle,
// plus directed vectors with literal expected values.
module tb_alu_muldiv;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic             flush = 1'b0;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} straight from the arithmetic definition
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        p  = '0;
        case (o)
            3'd0: p = 64'(sx * sy);
            3'd1: p = ux * uy;
            3'd2, 3'd3: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else if (o == 3'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end else begin
                    q = longint'(ux / uy);
                    r = longint'(ux % uy);
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    logic        m_valid = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_left  = 0;
            m_hi    = '0;
            m_lo    = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy = 1'b0;
                end else if (m_left == 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_hi   = r_hi;
                    m_lo   = r_lo;
                end else begin
                    m_left--;
                end
            end else if (start) begin
                case (op)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        {r_hi, r_lo} = ref_result(op, a, b);
                        m_busy = 1'b1;
                        m_left = WIDTH + 1;
                    end
                    3'd4: begin m_hi = a; m_done = 1'b1; end
                    3'd5: begin m_lo = a; m_done = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_busy", 64'(busy), 64'(m_busy));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_hi", 64'(hi), 64'(m_hi));
            check("cyc_lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
    endtask

    int n;
    logic [31:0] save_hi, save_lo;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done(n);
        check("t1_latency", 64'(n), 64'd33);
        check("t1_hi", 64'(hi), 64'hFFFF_FFFF);
        check("t1_lo", 64'(lo), 64'hFFFF_FFEB);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t2_b2b_busy", 64'(busy), 64'd1);
        wait_done(n);
        check("t2_latency", 64'(n), 64'd33);
        check("t2_hi", 64'(hi), 64'hFFFF_FFFE);
        check("t2_lo", 64'(lo), 64'h0000_0001);

        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(n);
        check("t3_lo", 64'(lo), 64'hFFFF_FFFD);
        check("t3_hi", 64'(hi), 64'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        check("t3_ovf_lo", 64'(lo), 64'h8000_0000);
        check("t3_ovf_hi", 64'(hi), 64'h0);

        issue(3'd3, 32'h0000_0064, 32'h0);
        wait_done(n);
        check("t4_dz_latency", 64'(n), 64'd33);
        check("t4_dz_lo", 64'(lo), 64'hFFFF_FFFF);
        check("t4_dz_hi", 64'(hi), 64'h0000_0064);

        issue(3'd4, 32'h1234_5678, 32'h0);
        check("t4_mthi_busy", 64'(busy), 64'd0);
        check("t4_mthi_done", 64'(done), 64'd1);
        check("t4_mthi_hi", 64'(hi), 64'h1234_5678);
        check("t4_mthi_lo", 64'(lo), 64'hFFFF_FFFF);

        save_hi = hi;
        save_lo = lo;
        issue(3'd0, 32'd5, 32'd6);
        for (int i = 0; i < 4; i++) tick();
        issue(3'd5, 32'h0000_AAAA, 32'h0);
        check("t5_ign_busy", 64'(busy), 64'd1);
        check("t5_ign_lo", 64'(lo), 64'(save_lo));
        issue(3'd2, 32'd99, 32'd3);
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            check("t5_no_done", 64'(done), 64'd0);
            tick();
        end
        check("t5_hi_kept", 64'(hi), 64'(save_hi));
        check("t5_lo_kept", 64'(lo), 64'(save_lo));

        flush = 1'b1;
        issue(3'd5, 32'hCAFE_F00D, 32'h0);
        flush = 1'b0;
        check("t5_idle_flush_done", 64'(done), 64'd1);
        check("t5_idle_flush_lo", 64'(lo), 64'hCAFE_F00D);

        issue(3'd6, 32'h5555_5555, 32'h1);
        check("t5_undef_busy", 64'(busy), 64'd0);
        check("t5_undef_done", 64'(done), 64'd0);
        check("t5_undef_hi", 64'(hi), 64'(save_hi));

        issue(3'd2, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) tick();
        @(posedge clk);
        #2 rstn = 1'b0;
        #2 rstn = 1'b1;
        #3;
        check("t6_glitch_busy", 64'(busy), 64'd1);
        check("t6_glitch_lo", 64'(lo), 64'hCAFE_F00D);
        #2;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_hi", 64'(hi), 64'd0);
        check("t6_rst_lo", 64'(lo), 64'd0);

        issue(3'd0, 32'd7, 32'hFFFF_FFF7);
        wait_done(n);
        check("x_mult_lo", 64'(lo), 64'hFFFF_FFC1);
        issue(3'd3, 32'hFFFF_FFFF, 32'd10);
        wait_done(n);
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done(n);
        check("x_div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("x_div_hi", 64'(hi), 64'h0000_0001);
        issue(3'd2, 32'hFFFF_FFF0, 32'h0);
        wait_done(n);
        check("x_divz_hi", 64'(hi), 64'hFFFF_FFF0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
